// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory completer: FSM states, bus-width
// defaults, the wait-state ceiling and an index-width helper.
package apb_pkg;

  localparam int APB_ADDR_W   = 8;
  localparam int APB_DATA_W   = 8;
  localparam int APB_MAX_WAIT = 15;
  localparam int WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

  // Index width for a word array; never narrower than one bit.
  function automatic int apb_index_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage: synchronous write, combinational read, synchronous clear.
// Slots above DEPTH in the power-of-two index space read back as zero.
module apb_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int SLOTS = 1 << AW;

  logic [DATA_W-1:0] words [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (clr) begin
          word_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign words[gi] = word_reg;
    end

    for (gi = DEPTH; gi < SLOTS; gi++) begin : g_pad
      assign words[gi] = '0;
    end
  endgenerate

  assign rdata = words[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer backed by a word array, with a fixed number of wait states
// per transfer, out-of-range error reporting and abort on early psel drop.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int MEM_AW = apb_index_width(DEPTH);
  localparam logic [ADDR_W:0]       DEPTH_LIM = DEPTH;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  apb_state_e            state_reg, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [ADDR_W-1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic                  write_reg;
  logic                  pready_reg;
  logic                  pslverr_reg;
  logic [DATA_W-1:0]     prdata_hold_reg;

  logic                  capture;
  logic                  paddr_err;
  logic                  addr_err;
  logic                  err_next;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     rd_value;

  assign paddr_err = ({1'b0, paddr} >= DEPTH_LIM);
  assign addr_err  = ({1'b0, addr_reg} >= DEPTH_LIM);
  assign err_next  = capture ? paddr_err : addr_err;
  assign rd_value  = addr_err ? '0 : mem_rdata;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg       <= ST_IDLE;
      wait_cnt_reg    <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      write_reg       <= 1'b0;
      pready_reg      <= 1'b0;
      pslverr_reg     <= 1'b0;
      prdata_hold_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (capture) begin
        addr_reg  <= paddr;
        wdata_reg <= pwdata;
        write_reg <= pwrite;
      end
      pready_reg  <= (state_next == ST_READY);
      pslverr_reg <= (state_next == ST_READY) && err_next;
      if ((state_reg == ST_READY) && !write_reg) begin
        prdata_hold_reg <= rd_value;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    capture       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        capture = psel && !penable;
      end
      ST_WAIT: begin
        if (!psel) begin
          state_next = ST_IDLE;
        end else if (penable) begin
          if (wait_cnt_reg == '0) begin
            state_next = ST_READY;
          end else begin
            wait_cnt_next = wait_cnt_reg - CNT_ONE;
          end
        end
      end
      ST_READY: begin
        state_next = ST_IDLE;
        capture    = psel && !penable;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (capture) begin
      state_next    = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
      wait_cnt_next = WAIT_LOAD;
    end
  end

  // A write lands only when the READY cycle ends with the completer still selected.
  always_comb begin
    mem_we = 1'b0;
    prdata = prdata_hold_reg;
    if (state_reg == ST_READY) begin
      if (!write_reg) begin
        prdata = rd_value;
      end
      mem_we = write_reg && psel && !addr_err;
    end
  end

  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (pclk),
    .clr   (!presetn),
    .we    (mem_we),
    .waddr (addr_reg[MEM_AW-1:0]),
    .wdata (wdata_reg),
    .raddr (addr_reg[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter DEPTH, default 256, number of storage words; DEPTH ≤ 2^ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 1, wait states inserted per transfer; range 0..15.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 pclk  input  1  bus clock; all state changes on its rising edge.
REQ-007 presetn  input  1  synchronous active-low reset.
REQ-008 psel  input  1  completer select.
REQ-009 penable  input  1  access-phase indicator.
REQ-010 pwrite  input  1  1 = write, 0 = read.
REQ-011 paddr  input  ADDR_W  word address.
REQ-012 pwdata  input  DATA_W  write data.
REQ-013 prdata  output  DATA_W  read data; valid only while pready = 1 and pwrite = 0.
REQ-014 pready  output  1  transfer completion; registered.
REQ-015 pslverr  output  1  error flag; valid only while pready = 1.

Function
REQ-016 States: IDLE, WAIT and READY; encoding from the shared package.
REQ-017 IDLE: on the edge that samples psel = 1 and penable = 0, capture paddr, pwrite and pwdata; go to READY if WAIT_CYCLES = 0, else go to WAIT with the wait counter loaded to WAIT_CYCLES-1.
REQ-018 Let T1 be the first cycle with psel = 1 and penable = 1; pready is high in cycle T1+WAIT_CYCLES only, for exactly one cycle.
REQ-019 WAIT: decrement the counter each edge while psel = 1 and penable = 1; at 0, go to READY and register pready = 1.
REQ-020 READY: pready = 1; at the ending edge, clear pready and go to IDLE. If that edge also samples psel = 1 and penable = 0 (back-to-back), apply the REQ-017 capture instead of idling.
REQ-021 Writes commit at the edge ending the READY cycle, using the captured address and data; no other cycle modifies storage.
REQ-022 Reads drive prdata from storage at the captured address during the READY cycle; a read of a word written by the immediately preceding transfer returns the new value.
REQ-023 Captured address ≥ DEPTH: pslverr = 1 with pready; no write occurs; prdata = 0.
REQ-024 psel = 0 in WAIT or READY (abort): return to IDLE next edge; pready and pslverr = 0; no write.
REQ-025 Changes on paddr, pwdata or pwrite after capture are ignored until the next capture.
REQ-026 prdata holds its last value outside READY; pslverr = 0 outside READY.

Reset
REQ-027 With presetn = 0 at an edge: state = IDLE, pready = 0, pslverr = 0, prdata = 0, wait counter = 0, all storage words = 0.
REQ-028 Reset asserted mid-transfer discards the transfer; no write commits at that edge.
REQ-029 After presetn returns to 1, the first capture occurs no earlier than the following edge.

Structure
REQ-030 Shared package apb_pkg holds the state enum, the default ADDR_W and DATA_W, and the max-wait constant (15).
REQ-031 Storage is one sub-module, apb_mem_array: a synchronous-write, combinational-read word array with a synchronous clear.
REQ-032 The FSM, capture registers and wait counter are in apb_mem_slave.

Verification
REQ-033 Write 0x5A to 0x10, then read 0x10, WAIT_CYCLES=1 -> each pready high exactly in T1+1; read prdata = 0x5A; pslverr = 0.
REQ-034 WAIT_CYCLES=0, back-to-back write 0x3C@0x20 then read 0x20 with psel held high -> pready in T1 of each transfer; read returns 0x3C.
REQ-035 DEPTH=128, write 0xFF@0x80 -> pslverr = 1 with pready; a later read of 0x00 returns 0x00.
REQ-036 WAIT_CYCLES=3, psel dropped in the second access cycle of a write 0x11@0x05 -> no pready; a read of 0x05 returns 0x00.
REQ-037 presetn = 0 for one edge during WAIT of a write 0x77@0x01 -> outputs are 0 next cycle; a read of 0x01 returns 0x00.
REQ-038 Change pwdata from 0xAA to 0xBB after capture of a write to 0x02 -> a read of 0x02 returns 0xAA.
